// File: rtl/control_fsm.sv
// control_fsm -- multi-cycle control unit for a small RV32I subset
// (addi, slli, add, bne, lw, sw).
//
// One instruction is accepted through a valid/ready handshake. It then passes
// through DECODE, EXECUTE, an optional MEMORY phase and an optional WRITEBACK
// phase before the unit returns to IDLE. All strobes are registered and depend
// only on the state and the decoded class. They never depend combinationally
// on instr_in.
//
// Ports
//   clk, rst        : clock and asynchronous active-high reset
//   instr_in        : instruction word; sampled only on the handshake edge
//   instr_valid_in  : instr_in is valid
//   instr_ready_out : unit is IDLE and out of reset
//   EQ_in           : ALU equality flag; used to resolve bne
//   mem_ready_in    : data-memory access complete; used only in MEMORY
//   ALUctrl_out     : 000 add, 001 shift-left-by-1
//   ALUsrc_out      : 0 register operand, 1 immediate operand
//   RegWrite_out, MemRead_out, MemWrite_out, PCsrc_out, illegal_out : strobes
module control_fsm #(
  parameter int ADDRESS_WIDTH = 3,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    instr_in,
  input  logic                     instr_valid_in,
  output logic                     instr_ready_out,
  input  logic                     EQ_in,
  input  logic                     mem_ready_in,
  output logic [ADDRESS_WIDTH-1:0] ALUctrl_out,
  output logic                     ALUsrc_out,
  output logic                     RegWrite_out,
  output logic                     MemRead_out,
  output logic                     MemWrite_out,
  output logic                     PCsrc_out,
  output logic                     illegal_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_ADDI = 3'd0,
    C_SLLI = 3'd1,
    C_ADD  = 3'd2,
    C_BNE  = 3'd3,
    C_LW   = 3'd4,
    C_SW   = 3'd5,
    C_ILL  = 3'd6
  } cls_t;

  // Decode is done once, on the word that is being latched. Only the class is
  // kept, because the operand fields are not needed by the control path.
  function automatic cls_t decode_f(input logic [31:0] w);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    cls_t       c;
    opc = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    c   = C_ILL;
    case (opc)
      7'b0010011: begin
        if (f3 == 3'b000) c = C_ADDI;
        else if (f3 == 3'b001 && f7 == 7'b0000000) c = C_SLLI;
        else c = C_ILL;
      end
      7'b0110011: begin
        if (f3 == 3'b000 && f7 == 7'b0000000) c = C_ADD;
        else c = C_ILL;
      end
      7'b1100011: begin
        if (f3 == 3'b001) c = C_BNE;
        else c = C_ILL;
      end
      7'b0000011: begin
        if (f3 == 3'b010) c = C_LW;
        else c = C_ILL;
      end
      7'b0100011: begin
        if (f3 == 3'b010) c = C_SW;
        else c = C_ILL;
      end
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  state_t                   state_q, state_d;
  cls_t                     cls_q, cls_d;
  logic                     eq_q, eq_d;
  logic [ADDRESS_WIDTH-1:0] alu_ctrl_q, alu_ctrl_d;
  logic                     alu_src_q, alu_src_d;
  logic                     reg_write_q, reg_write_d;
  logic                     mem_read_q, mem_read_d;
  logic                     mem_write_q, mem_write_d;
  logic                     pc_src_q, pc_src_d;
  logic                     illegal_q, illegal_d;
  logic                     ready_s;
  logic                     handshake_s;
  logic                     unused_instr_s;

  // Ready is gated by rst directly so that it reads 0 for the whole reset
  // pulse and 1 as soon as the unit is idle after release.
  assign ready_s         = (state_q == IDLE) & ~rst;
  assign handshake_s     = instr_valid_in & ready_s;
  assign instr_ready_out = ready_s;
  assign unused_instr_s  = ^{instr_in[24:15], instr_in[11:7]};

  // Next-state logic, class latch, and registered Moore outputs for the next state.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    eq_d    = eq_q;
    case (state_q)
      IDLE: begin
        if (handshake_s) begin
          state_d = DECODE;
          cls_d   = decode_f(instr_in[31:0]);
        end else begin
          state_d = IDLE;
        end
      end
      DECODE: begin
        if (cls_q == C_ILL) begin
          state_d = IDLE;
        end else begin
          state_d = EXECUTE;
          // The branch condition is captured on entry to EXECUTE so that
          // PCsrc can be a registered strobe.
          eq_d    = EQ_in;
        end
      end
      EXECUTE: begin
        case (cls_q)
          C_ADDI, C_SLLI, C_ADD: state_d = WRITEBACK;
          C_LW, C_SW:            state_d = MEMORY;
          default:               state_d = IDLE;
        endcase
      end
      MEMORY: begin
        if (mem_ready_in) begin
          if (cls_q == C_LW) state_d = WRITEBACK;
          else state_d = IDLE;
        end else begin
          state_d = MEMORY;
        end
      end
      WRITEBACK: state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // The outputs are computed for the state being entered. The flops then
    // present them during that state.
    alu_ctrl_d = {ADDRESS_WIDTH{1'b0}};
    alu_src_d  = 1'b0;
    if (state_d == EXECUTE || state_d == MEMORY) begin
      case (cls_d)
        C_SLLI: begin
          alu_ctrl_d = ADDRESS_WIDTH'(1);
          alu_src_d  = 1'b1;
        end
        C_ADDI, C_LW, C_SW: alu_src_d = 1'b1;
        default:            alu_src_d = 1'b0;
      endcase
    end else begin
      alu_src_d = 1'b0;
    end
    illegal_d   = (state_d == DECODE)  && (cls_d == C_ILL);
    pc_src_d    = (state_d == EXECUTE) && (cls_d == C_BNE) && !eq_d;
    mem_read_d  = (state_d == MEMORY)  && (cls_d == C_LW);
    mem_write_d = (state_d == MEMORY)  && (cls_d == C_SW);
    reg_write_d = (state_d == WRITEBACK);
  end

  // State and output registers; reset clears all of them immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cls_q       <= C_ILL;
      eq_q        <= 1'b0;
      alu_ctrl_q  <= {ADDRESS_WIDTH{1'b0}};
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      pc_src_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      eq_q        <= eq_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_src_q   <= alu_src_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      pc_src_q    <= pc_src_d;
      illegal_q   <= illegal_d;
    end
  end

  assign ALUctrl_out  = alu_ctrl_q;
  assign ALUsrc_out   = alu_src_q;
  assign RegWrite_out = reg_write_q;
  assign MemRead_out  = mem_read_q;
  assign MemWrite_out = mem_write_q;
  assign PCsrc_out    = pc_src_q;
  assign illegal_out  = illegal_q;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm.
// Each stimulus step pushes the output vector expected for every busy cycle of
// its instruction. The monitor pops one entry on every falling edge where the
// DUT is busy or drives a nonzero output, and compares the whole vector.
// Vector layout: {ready, ALUctrl[2:0], ALUsrc, RegWrite, MemRead, MemWrite, PCsrc, illegal}.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in;
  logic        instr_valid_in;
  logic        instr_ready_out;
  logic        EQ_in;
  logic        mem_ready_in;
  logic [2:0]  ALUctrl_out;
  logic        ALUsrc_out;
  logic        RegWrite_out;
  logic        MemRead_out;
  logic        MemWrite_out;
  logic        PCsrc_out;
  logic        illegal_out;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [9:0]  exp_q[$];

  control_fsm #(.ADDRESS_WIDTH(3), .DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .instr_in        (instr_in),
    .instr_valid_in  (instr_valid_in),
    .instr_ready_out (instr_ready_out),
    .EQ_in           (EQ_in),
    .mem_ready_in    (mem_ready_in),
    .ALUctrl_out     (ALUctrl_out),
    .ALUsrc_out      (ALUsrc_out),
    .RegWrite_out    (RegWrite_out),
    .MemRead_out     (MemRead_out),
    .MemWrite_out    (MemWrite_out),
    .PCsrc_out       (PCsrc_out),
    .illegal_out     (illegal_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] obs_f();
    return {instr_ready_out, ALUctrl_out, ALUsrc_out, RegWrite_out,
            MemRead_out, MemWrite_out, PCsrc_out, illegal_out};
  endfunction

  // Expected vector for a busy cycle (ready is 0).
  function automatic logic [9:0] ev(input logic [2:0] alu, input logic src,
                                    input logic rw, input logic mr,
                                    input logic mw, input logic pc,
                                    input logic ill);
    return {1'b0, alu, src, rw, mr, mw, pc, ill};
  endfunction

  task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  // Monitor: every cycle in which the DUT is busy or drives a strobe is matched
  // against the next scoreboard entry.
  always @(negedge clk) begin
    logic [9:0] o;
    logic [9:0] e;
    if (rst === 1'b0) begin
      o = obs_f();
      if (o[9] !== 1'b1 || o[8:0] !== 9'd0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_output: got %b expected idle with no strobe", o);
        end else begin
          e = exp_q.pop_front();
          if (o === e) n_pass++;
          else $display("FAIL cycle_%0d_outputs: got %b expected %b", cyc, o, e);
        end
      end
    end
  end

  // Offers one word, waits for the handshake, and optionally drives mem_ready
  // high in the nmem-th MEMORY cycle.
  task automatic issue(input logic [31:0] w, input int nmem, output int hs_cyc);
    int waited;
    waited = 0;
    @(negedge clk);
    while (instr_ready_out !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (instr_ready_out !== 1'b1) begin
      n_checks++;
      $display("FAIL ready_timeout: got ready=%b expected 1 within 50 cycles", instr_ready_out);
    end
    instr_in       = w;
    instr_valid_in = 1'b1;
    @(posedge clk);
    hs_cyc = cyc;
    #1;
    instr_valid_in = 1'b0;
    instr_in       = 32'hFFFF_FFFF;
    if (nmem > 0) begin
      mem_ready_in = 1'b0;
      repeat (1 + nmem) @(posedge clk);
      #1 mem_ready_in = 1'b1;
      @(posedge clk);
      #1 mem_ready_in = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL %s_drain: got %0d entries left expected 0", name, exp_q.size());
  endtask

  initial begin
    int h1;
    int h2;
    rst            = 1'b1;
    instr_in       = 32'h0;
    instr_valid_in = 1'b0;
    EQ_in          = 1'b0;
    mem_ready_in   = 1'b0;

    // Reset state, including ready held low during reset.
    #3 chk("reset_outputs", obs_f(), 10'b0);
    instr_valid_in = 1'b1;
    @(posedge clk); #1 chk("reset_hold", obs_f(), 10'b0);
    instr_valid_in = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1 chk("ready_after_release", obs_f(), 10'b10_0000_0000);

    // addi x1,x0,5
    exp_q.push_back(ev(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(32'h0050_0093, 0, h1);
    drain("addi");

    // add x3,x1,x2 then slli x1,x1,1 back to back
    exp_q.push_back(ev(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(32'h0020_81B3, 0, h1);
    exp_q.push_back(ev(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(32'h0010_9093, 0, h2);
    n_checks++;
    if (h2 - h1 == 4) n_pass++;
    else $display("FAIL back_to_back_gap: got %0d cycles expected 4", h2 - h1);
    drain("add_slli");

    // bne taken (EQ=0); mem_ready held high to show it is ignored
    EQ_in = 1'b0;
    mem_ready_in = 1'b1;
    exp_q.push_back(ev(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    issue(32'h0020_9463, 0, h1);
    drain("bne_taken");

    // bne not taken (EQ=1)
    EQ_in = 1'b1;
    exp_q.push_back(ev(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(32'h0020_9463, 0, h1);
    drain("bne_not_taken");
    EQ_in = 1'b0;
    mem_ready_in = 1'b0;

    // lw with four MEMORY cycles
    exp_q.push_back(ev(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++)
      exp_q.push_back(ev(3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(32'h0000_A283, 4, h1);
    drain("lw");

    // sw with a single MEMORY cycle
    exp_q.push_back(ev(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    issue(32'h0050_A223, 1, h1);
    drain("sw");

    // illegal word
    exp_q.push_back(ev(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    issue(32'hFFFF_FFFF, 0, h1);
    drain("illegal");

    // lw aborted by reset in its second MEMORY cycle
    exp_q.push_back(ev(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(32'h0000_A283, 0, h1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset_clear", obs_f(), 10'b0);
    repeat (2) @(posedge clk);
    #1 chk("reset_mid_mem_hold", obs_f(), 10'b0);
    @(negedge clk) rst = 1'b0;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL lw_abort_seen: got %0d entries left expected 0", exp_q.size());
    @(posedge clk); #1 chk("ready_after_abort", obs_f(), 10'b10_0000_0000);

    // Idle tail: any late strobe is reported by the monitor.
    repeat (8) @(posedge clk);
    #1 chk("final_idle", obs_f(), 10'b10_0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 3, SHALL set the width of ALUctrl_out.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the width of instr_in.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 instr_in  in  DATA_WIDTH  SHALL carry the RV32I instruction word offered for execution.
REQ-006 instr_valid_in  in  1  SHALL mark instr_in as valid.
REQ-007 instr_ready_out  out  1  SHALL indicate the block can accept an instruction.
REQ-008 EQ_in  in  1  SHALL be the ALU operand-equality flag.
REQ-009 mem_ready_in  in  1  SHALL indicate completion of the current data-memory access.
REQ-010 ALUctrl_out  out  ADDRESS_WIDTH  SHALL carry the ALU operation code: 000 add, 001 shift-left-by-1.
REQ-011 ALUsrc_out  out  1  SHALL select the ALU second operand: 0 register, 1 immediate.
REQ-012 RegWrite_out, MemRead_out, MemWrite_out, PCsrc_out, illegal_out  out  1 each  SHALL be the register-write, memory-read, memory-write, branch-taken, and illegal-instruction strobes.

Function
REQ-013 The FSM SHALL have the states IDLE, DECODE, EXECUTE, MEMORY, and WRITEBACK.
REQ-014 instr_ready_out SHALL be 1 exactly when the state is IDLE and rst is 0.
REQ-015 A handshake SHALL occur when instr_valid_in=1 and instr_ready_out=1; at that edge the block SHALL latch instr_in and go to DECODE; instr_in SHALL be ignored at all other times.
REQ-016 DECODE SHALL last one cycle and SHALL classify the latched word as one of: addi (opc 0010011, f3 000), slli (0010011, f3 001, f7 0000000), add (0110011, f3 000, f7 0000000), bne (1100011, f3 001), lw (0000011, f3 010), sw (0100011, f3 010), or illegal.
REQ-017 For an illegal word, DECODE SHALL assert illegal_out for that one cycle and go to IDLE with no other strobe asserted.
REQ-018 For a legal word, DECODE SHALL go to EXECUTE.
REQ-019 In EXECUTE, ALUctrl_out and ALUsrc_out SHALL be: addi 000/1; slli 001/1; add 000/0; bne 000/0; lw 000/1; sw 000/1.
REQ-020 In all states other than EXECUTE and MEMORY, ALUctrl_out and ALUsrc_out SHALL be 0.
REQ-021 In EXECUTE, bne SHALL assert PCsrc_out for that cycle iff EQ_in=0, then go to IDLE.
REQ-022 In EXECUTE, addi, slli, and add SHALL go to WRITEBACK, and lw and sw SHALL go to MEMORY.
REQ-023 MEMORY SHALL hold ALUctrl_out and ALUsrc_out at their EXECUTE values.
REQ-024 MEMORY SHALL assert MemRead_out (lw) or MemWrite_out (sw) in every cycle until the cycle in which mem_ready_in=1, inclusive.
REQ-025 On leaving MEMORY, lw SHALL go to WRITEBACK and sw SHALL go to IDLE; there SHALL be no timeout.
REQ-026 mem_ready_in SHALL be ignored outside MEMORY.
REQ-027 WRITEBACK SHALL assert RegWrite_out for exactly one cycle, then go to IDLE.
REQ-028 Latency from handshake to return to IDLE SHALL be: ALU ops 4 cycles; bne 3 cycles; illegal 2 cycles; lw 4+N cycles and sw 3+N cycles, where N ≥ 1 is the number of MEMORY cycles.
REQ-029 All strobes SHALL be mutually exclusive, and each SHALL be a pure function of the state and the latched instruction (Moore outputs, no combinational path from instr_in).
REQ-030 Back-to-back operation SHALL be supported: a new handshake SHALL be accepted in the first IDLE cycle after completion.

Reset
REQ-031 While rst=1, the state SHALL be IDLE and every output, including instr_ready_out, SHALL be 0.
REQ-032 When rst asserts in any state (including mid-MEMORY), all outputs SHALL go to 0 immediately (asynchronously) and the in-flight instruction SHALL be discarded without any write strobe.
REQ-033 After rst deasserts, instr_ready_out SHALL be 1 from the first clock edge onward.

Verification
REQ-034 addi x1,x0,5 (0x00500093) → DECODE; EXECUTE with ALUctrl 000, ALUsrc 1; WRITEBACK with RegWrite 1 for one cycle; instr_ready_out back to 1 four cycles after the handshake.
REQ-035 add x3,x1,x2 (0x002081B3), then immediately slli x1,x1,1 (0x00109093) → EXECUTE ALUsrc 0 then ALUctrl 001/ALUsrc 1; each gets exactly one RegWrite pulse; second handshake accepted in the first IDLE cycle after the first completes.
REQ-036 bne x1,x2,8 (0x00209463) with EQ_in=0 → PCsrc 1 in EXECUTE; repeated with EQ_in=1 → PCsrc stays 0; RegWrite stays 0 throughout.
REQ-037 lw x5,0(x1) (0x0000A283) with mem_ready_in held 0 for 3 cycles then 1 → MemRead 1 for 4 cycles, then one RegWrite cycle; sw x5,4(x1) (0x0050A223) with mem_ready_in=1 at once → MemWrite for one cycle, no RegWrite.
REQ-038 0xFFFFFFFF → illegal_out 1 for one cycle in DECODE, no other strobe, back in IDLE 2 cycles after the handshake.
REQ-039 rst pulsed during the second MEMORY cycle of lw → outputs 0 immediately, no RegWrite ever, instr_ready_out 1 at the first edge after release.
